mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller between the CPU pipeline and the 8-bit unified RAM. It serves two request ports: instruction fetch (IF stage) and data access (MEM stage). It arbitrates between them, splits each access into 1, 2 or 4 little-endian byte transfers, and returns assembled words with busy/done handshakes. IF fetches can be cancelled on a branch redirect.

## Interface
- `ADDR_W`, default 17: physical RAM address width; `ram_a` carries the low `ADDR_W` bits of the byte address.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_re`  in  1  IF read request (level; held until `if_done`).
- `if_addr`  in  32  IF word address.
- `if_flush`  in  1  branch redirect; cancels a pending or in-flight IF read.
- `if_busy`  out  1  IF request pending or in progress.
- `if_done`  out  1  one-cycle pulse; `if_data` valid.
- `if_data`  out  32  fetched instruction; held until the next IF completion.
- `mem_re`, `mem_we`  in  1  data read / write request (level; mutually exclusive).
- `mem_addr`  in  32  data byte address.
- `mem_width`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `mem_wdata`  in  32  write data; low bytes used.
- `mem_busy`  out  1  data request pending or in progress.
- `mem_done`  out  1  one-cycle pulse; read data valid or write complete.
- `mem_data`  out  32  read data, zero-extended; held until the next data read completes.
- `ram_a`  out  ADDR_W  RAM byte address.
- `ram_dout`  out  8  RAM write data.
- `ram_wr`  out  1  RAM write strobe.
- `ram_din`  in  8  RAM read data, valid one cycle after its address.

## Operation
- States: IDLE, RD, WR. A byte counter `cnt` tracks progress, and `n` (1/2/4) is the length latched at accept.
- Pending flags: `if_pend` and `mem_pend` are set in the first cycle the corresponding request is sampled high and not yet served. Each `*_busy` output equals its pending flag, registered.
- Arbitration happens in IDLE only. The data port has priority over IF. The losing port stays pending and is served next.
- IF accesses are always word reads.
- Accept: latch the address, `n` and the write data, then enter RD or WR.
- RD: drive `ram_a` = base+`cnt` for `cnt` = 0..n-1. Capture `ram_din` one cycle later into byte lane `cnt`. After the last capture, pulse `done` and return to IDLE.
- WR: drive `ram_a` = base+`cnt`, `ram_dout` = `wdata[8cnt+7:8cnt]` and `ram_wr`=1 for n cycles. Then pulse `done` and return to IDLE.
- Re-accept guard: a port is not re-accepted in the cycle its `done` is high. Its request is resampled from the following cycle onward.
- `if_flush`:
  - Clears `if_pend`.
  - If an IF read is in RD, the read is aborted: next state IDLE, no `if_done`, `if_data` unchanged.
  - An `if_re` seen in the same cycle as `if_flush` is ignored.
  - Data-port operations are never affected.
- In IDLE: `ram_wr`=0, `ram_a`=0, `ram_dout`=0.

## Timing
- Reset values: all outputs 0, state IDLE, pending flags 0, `if_data`/`mem_data` 0. Reset mid-transfer drops `ram_wr` and aborts without a `done` pulse.
- Request sampled in IDLE at cycle T:
  - `ram_a` is driven during T+1..T+n.
  - Read bytes are captured during T+2..T+n+1.
  - Read `done` occurs at T+n+2; a word read is therefore 6 cycles request-to-done.
  - Write `done` occurs at T+n+1.
- `busy` is high from T+1 up to, but not including, the `done` cycle. `busy` is low and `done` is high together in the done cycle. This lets a consumer latch data on `!busy` after having seen `busy`.
- Back-to-back: the losing port is accepted in the `done` cycle of the winner, if still pending. That gives one IDLE cycle between transfers.
- Address arithmetic is base+`cnt` modulo 2^ADDR_W. Wrap-around at the top of RAM is legal.

## Structure
- Shared constants go in `defines.v`: `MemAddrBus`, `RegBus`, width codes (`MEM_B`, `MEM_H`, `MEM_W`), and the state encodings.
- Single module. No sub-module is needed; byte-lane assembly and arbitration are both small enough to stay inline.

## Test plan
- IF word read: RAM[0x100..0x103] = 13,05,10,00, `if_re` at T with `if_addr`=0x100. Expect `ram_a` = 0x100..0x103 during T+1..T+4, `if_done` at T+6, `if_data`=0x00100513, and `if_busy` high T+1..T+5.
- Data byte write: `mem_we` with addr 0x2001, width 00, wdata 0xAB. Expect a single `ram_wr` cycle with `ram_dout`=0xAB, then `mem_done` at T+2.
- Half read: 0x3000 holding FF,80. Expect `mem_data`=0x000080FF (zero-extended) and `done` at T+4.
- Contention: `if_re` and `mem_re` (word) both asserted at T. Expect the data read `done` at T+6, the IF accepted at T+6, and `if_done` at T+12, with `if_busy` high throughout.
- Flush: `if_flush` at T+3 of an IF read. Expect IDLE at T+4, no `if_done`, `if_data` unchanged, and `if_busy` low from T+4.
- Reset mid-write: `rst` at T+2 of a word write. Expect `ram_wr`=0 from T+3, all outputs 0, and no `mem_done`.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state encoding and width decoding for the byte-serial
// memory controller.
package mem_ctrl_pkg;

  localparam int RegBus     = 32;
  localparam int MemAddrBus = 17;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  // Width code 11 is treated the same as a full word.
  function automatic logic [2:0] width_len(input logic [1:0] width);
    case (width)
      MEM_B:   width_len = 3'd1;
      MEM_H:   width_len = 3'd2;
      default: width_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the IF and MEM ports onto the 8-bit unified RAM and splits each
// access into little-endian byte transfers.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = MemAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_re,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic              if_busy,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [1:0]        mem_width,
  input  logic [31:0]       mem_wdata,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [31:0]       mem_data,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  state_t              state;
  logic [2:0]          cnt;
  logic [2:0]          n;
  logic [ADDR_W-1:0]   base;
  logic [RegBus-1:0]   wdata;
  logic [RegBus-1:0]   rbuf;
  logic                sel_if;
  logic                if_pend;
  logic                mem_pend;

  logic                if_req;
  logic                mem_req;
  logic [2:0]          cnt_inc;
  logic [ADDR_W-1:0]   addr_next;
  logic [1:0]          lane;
  logic [RegBus-1:0]   rbuf_nx;
  logic                unused_addr;

  // Only the low ADDR_W bits of either address reach the RAM.
  assign unused_addr = ^{if_addr, mem_addr};

  assign if_busy  = if_pend;
  assign mem_busy = mem_pend;

  always_comb begin
    if_req    = ~if_flush & (if_pend | (if_re & ~if_done));
    mem_req   = mem_pend | ((mem_re | mem_we) & ~mem_done);
    cnt_inc   = cnt + 3'd1;
    addr_next = base + ADDR_W'(cnt_inc);
    // The byte arriving now belongs to the address issued one cycle earlier.
    lane      = cnt[1:0] - 2'd1;
    rbuf_nx   = rbuf;
    rbuf_nx[{lane, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      n        <= '0;
      base     <= '0;
      wdata    <= '0;
      rbuf     <= '0;
      sel_if   <= 1'b0;
      if_pend  <= 1'b0;
      mem_pend <= 1'b0;
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      if_data  <= '0;
      mem_data <= '0;
      ram_a    <= '0;
      ram_dout <= '0;
      ram_wr   <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;

      if (if_flush)
        if_pend <= 1'b0;
      else if (if_re && !if_done)
        if_pend <= 1'b1;
      if ((mem_re || mem_we) && !mem_done)
        mem_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (mem_req) begin
            base   <= mem_addr[ADDR_W-1:0];
            n      <= width_len(mem_width);
            wdata  <= mem_wdata;
            rbuf   <= '0;
            cnt    <= '0;
            sel_if <= 1'b0;
            ram_a  <= mem_addr[ADDR_W-1:0];
            if (mem_we) begin
              state    <= WR;
              ram_wr   <= 1'b1;
              ram_dout <= mem_wdata[7:0];
            end else begin
              state <= RD;
            end
          end else if (if_req) begin
            base   <= if_addr[ADDR_W-1:0];
            n      <= 3'd4;
            rbuf   <= '0;
            cnt    <= '0;
            sel_if <= 1'b1;
            ram_a  <= if_addr[ADDR_W-1:0];
            state  <= RD;
          end
        end

        RD: begin
          if (sel_if && if_flush) begin
            state <= IDLE;
            cnt   <= '0;
            ram_a <= '0;
          end else begin
            if (cnt != 3'd0)
              rbuf <= rbuf_nx;
            if (cnt == n) begin
              state <= IDLE;
              cnt   <= '0;
              if (sel_if) begin
                if_data <= rbuf_nx;
                if_done <= 1'b1;
                if_pend <= 1'b0;
              end else begin
                mem_data <= rbuf_nx;
                mem_done <= 1'b1;
                mem_pend <= 1'b0;
              end
            end else begin
              cnt   <= cnt_inc;
              ram_a <= (cnt_inc < n) ? addr_next : '0;
            end
          end
        end

        WR: begin
          if (cnt == n - 3'd1) begin
            state    <= IDLE;
            cnt      <= '0;
            ram_wr   <= 1'b0;
            ram_a    <= '0;
            ram_dout <= '0;
            mem_done <= 1'b1;
            mem_pend <= 1'b0;
          end else begin
            cnt      <= cnt_inc;
            ram_a    <= addr_next;
            ram_dout <= wdata[{cnt_inc[1:0], 3'b000} +: 8];
          end
        end

        default: begin
          state  <= IDLE;
          ram_wr <= 1'b0;
          ram_a  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a table of single transfers against a byte RAM
// model, plus hand-written contention, flush and reset sequences.
module tb_mem_ctrl;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_re, if_flush, if_busy, if_done;
  logic [31:0]       if_addr, if_data;
  logic              mem_re, mem_we, mem_busy, mem_done;
  logic [31:0]       mem_addr, mem_wdata, mem_data;
  logic [1:0]        mem_width;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout, ram_din;
  logic              ram_wr;

  logic [7:0] ram [0:(1<<ADDR_W)-1];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    bit          is_if;
    bit          we;
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [15];

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_re    (if_re),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_busy  (if_busy),
    .if_done  (if_done),
    .if_data  (if_data),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_width(mem_width),
    .mem_wdata(mem_wdata),
    .mem_busy (mem_busy),
    .mem_done (mem_done),
    .mem_data (mem_data),
    .ram_a    (ram_a),
    .ram_dout (ram_dout),
    .ram_wr   (ram_wr),
    .ram_din  (ram_din)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears one cycle after its address.
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a] <= ram_dout;
    ram_din <= ram[ram_a];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request, waits for its done pulse, then holds the request
  // through the done edge to make sure it is not accepted a second time.
  task automatic applyStimulus(input vec_t v);
    int          cyc;
    int          gaps;
    logic        seen;
    logic        bsy;
    logic [31:0] a0;
    if (v.is_if) begin
      if_re   = 1'b1;
      if_addr = v.addr;
    end else begin
      mem_re    = !v.we;
      mem_we    = v.we;
      mem_addr  = v.addr;
      mem_width = v.width;
      mem_wdata = v.wdata;
    end
    cyc  = 0;
    gaps = 0;
    seen = 1'b0;
    a0   = '0;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      if (cyc == 1) a0 = 32'(ram_a);
      seen = v.is_if ? if_done : mem_done;
      bsy  = v.is_if ? if_busy : mem_busy;
      if (seen == bsy) gaps++;
    end
    checkOutput({v.name, " latency"}, 32'(cyc), 32'(v.exp_lat));
    checkOutput({v.name, " first addr"}, a0, {15'b0, v.addr[ADDR_W-1:0]});
    checkOutput({v.name, " busy window"}, 32'(gaps), 32'd0);
    if (v.is_if)
      checkOutput({v.name, " if_data"}, if_data, v.exp_data);
    else
      checkOutput({v.name, " mem_data"}, mem_data, v.exp_data);
    tick();
    checkOutput({v.name, " no reaccept"}, {if_busy, mem_busy, ram_wr, 4'b0, 8'(ram_a), 17'b0},
                32'd0);
    if_re  = 1'b0;
    mem_re = 1'b0;
    mem_we = 1'b0;
  endtask

  initial begin
    int          md, id, gaps, dones;
    logic [31:0] md_data;

    rst       = 1'b1;
    if_re     = 1'b0;
    if_addr   = '0;
    if_flush  = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_width = '0;
    mem_wdata = '0;

    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= 8'h00;
    ram[17'h00100] <= 8'h13; ram[17'h00101] <= 8'h05;
    ram[17'h00102] <= 8'h10; ram[17'h00103] <= 8'h00;
    ram[17'h03000] <= 8'hFF; ram[17'h03001] <= 8'h80;
    ram[17'h04000] <= 8'h11; ram[17'h04001] <= 8'h22;
    ram[17'h04002] <= 8'h33; ram[17'h04003] <= 8'h44;
    ram[17'h05005] <= 8'h9C;

    vecs[0]  = '{"if_word",     1'b1, 1'b0, 32'h0000_0100, 2'b10, 32'h0,         32'h0010_0513, 6};
    vecs[1]  = '{"wr_byte",     1'b0, 1'b1, 32'h0000_2001, 2'b00, 32'h1234_56AB, 32'h0000_0000, 2};
    vecs[2]  = '{"rd_byte_back",1'b0, 1'b0, 32'h0000_2001, 2'b00, 32'h0,         32'h0000_00AB, 3};
    vecs[3]  = '{"rd_half_back",1'b0, 1'b0, 32'h0000_2001, 2'b01, 32'h0,         32'h0000_00AB, 4};
    vecs[4]  = '{"rd_half",     1'b0, 1'b0, 32'h0000_3000, 2'b01, 32'h0,         32'h0000_80FF, 4};
    vecs[5]  = '{"rd_word",     1'b0, 1'b0, 32'h0000_4000, 2'b10, 32'h0,         32'h4433_2211, 6};
    vecs[6]  = '{"rd_width3",   1'b0, 1'b0, 32'h0000_4000, 2'b11, 32'h0,         32'h4433_2211, 6};
    vecs[7]  = '{"rd_byte_zx",  1'b0, 1'b0, 32'h0000_5005, 2'b00, 32'h0,         32'h0000_009C, 3};
    vecs[8]  = '{"wr_word",     1'b0, 1'b1, 32'h0000_6000, 2'b10, 32'hCAFE_F00D, 32'h0000_009C, 5};
    vecs[9]  = '{"rd_word_back",1'b0, 1'b0, 32'h0000_6000, 2'b10, 32'h0,         32'hCAFE_F00D, 6};
    vecs[10] = '{"wr_half",     1'b0, 1'b1, 32'h0000_6010, 2'b01, 32'h1234_BEEF, 32'hCAFE_F00D, 3};
    vecs[11] = '{"rd_half_wr",  1'b0, 1'b0, 32'h0000_6010, 2'b10, 32'h0,         32'h0000_BEEF, 6};
    vecs[12] = '{"wr_wrap",     1'b0, 1'b1, 32'h0001_FFFE, 2'b10, 32'h8765_4321, 32'h0000_BEEF, 5};
    vecs[13] = '{"rd_wrap",     1'b0, 1'b0, 32'h8001_FFFE, 2'b10, 32'h0,         32'h8765_4321, 6};
    vecs[14] = '{"if_word2",    1'b1, 1'b0, 32'h0000_6000, 2'b10, 32'h0,         32'hCAFE_F00D, 6};

    repeat (3) tick();
    checkOutput("reset flags", {27'b0, if_busy, if_done, mem_busy, mem_done, ram_wr}, 32'd0);
    checkOutput("reset ram_a", 32'(ram_a), 32'd0);
    checkOutput("reset ram_dout", 32'(ram_dout), 32'd0);
    checkOutput("reset if_data", if_data, 32'd0);
    checkOutput("reset mem_data", mem_data, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);
    checkOutput("ram wrap byte 0", 32'(ram[17'h00000]), 32'h0000_0065);
    checkOutput("ram byte past write", 32'(ram[17'h02002]), 32'd0);

    // Contention: data port wins, IF is taken in the data done cycle.
    if_re     = 1'b1;
    if_addr   = 32'h0000_0100;
    mem_re    = 1'b1;
    mem_addr  = 32'h0000_4000;
    mem_width = 2'b10;
    md = 0; id = 0; gaps = 0; md_data = '0;
    for (int c = 1; c <= 20 && id == 0; c++) begin
      tick();
      if (mem_done && md == 0) begin
        md      = c;
        md_data = mem_data;
      end
      if (if_done) id = c;
      else if (!if_busy) gaps++;
      if (c == 7) begin
        checkOutput("contend if accepted", 32'(ram_a), 32'h0000_0100);
        checkOutput("contend mem idle", {31'b0, mem_busy}, 32'd0);
        mem_re = 1'b0;
      end
    end
    checkOutput("contend mem done cycle", 32'(md), 32'd6);
    checkOutput("contend mem data", md_data, 32'h4433_2211);
    checkOutput("contend if done cycle", 32'(id), 32'd12);
    checkOutput("contend if busy gaps", 32'(gaps), 32'd0);
    checkOutput("contend if data", if_data, 32'h0010_0513);
    tick();
    if_re  = 1'b0;
    mem_re = 1'b0;
    tick();

    // Flush an IF read mid-transfer.
    if_re   = 1'b1;
    if_addr = 32'h0000_4000;
    repeat (3) tick();
    checkOutput("flush busy before", {31'b0, if_busy}, 32'd1);
    if_flush = 1'b1;
    tick();
    checkOutput("flush busy after", {31'b0, if_busy}, 32'd0);
    checkOutput("flush ram_a idle", 32'(ram_a), 32'd0);
    if_flush = 1'b0;
    if_re    = 1'b0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (if_done || if_busy) dones++;
    end
    checkOutput("flush no done", 32'(dones), 32'd0);
    checkOutput("flush if_data held", if_data, 32'h0010_0513);

    // Flush with a same-cycle IF request during a data read.
    mem_re    = 1'b1;
    mem_addr  = 32'h0000_4000;
    mem_width = 2'b01;
    tick();
    tick();
    if_re    = 1'b1;
    if_flush = 1'b1;
    tick();
    if_re    = 1'b0;
    if_flush = 1'b0;
    checkOutput("flush ignores if_re", {31'b0, if_busy}, 32'd0);
    tick();
    checkOutput("flush mem done", {31'b0, mem_done}, 32'd1);
    checkOutput("flush mem data", mem_data, 32'h0000_2211);
    tick();
    mem_re = 1'b0;
    checkOutput("flush no if accept", {30'b0, if_busy, mem_busy}, 32'd0);

    // Reset in the middle of a word write.
    mem_we    = 1'b1;
    mem_addr  = 32'h0000_7000;
    mem_width = 2'b10;
    mem_wdata = 32'h5566_7788;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rst mid flags", {27'b0, if_busy, if_done, mem_busy, mem_done, ram_wr}, 32'd0);
    checkOutput("rst mid ram_a", 32'(ram_a), 32'd0);
    checkOutput("rst mid ram_dout", 32'(ram_dout), 32'd0);
    checkOutput("rst mid data", if_data | mem_data, 32'd0);
    rst    = 1'b0;
    mem_we = 1'b0;
    dones  = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (mem_done) dones++;
    end
    checkOutput("rst mid no done", 32'(dones), 32'd0);
    checkOutput("rst mid byte0", 32'(ram[17'h07000]), 32'h0000_0088);
    checkOutput("rst mid byte2", 32'(ram[17'h07002]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
